bus_bridge_target_frame_codec: RTL
==================================

Name: bus_bridge_target_frame_codec

Overview:
- Remote (target) side of the UART bus bridge. Accepts one bus request from the local slave port and serialises it into the 4-byte request frame consumed by the master-side UART wrapper.
- Collects the 2-byte response frame and returns a completed response with an error/timeout indication.
- Sits between the target-side bus slave logic and the target-side UART byte adapter. Its tx byte stream drives the UART line that feeds the master wrapper's uart_rx.

Parameters:
- TIMEOUT_CYCLES, 5_000_000, clk cycles allowed between response bytes (and before the first) before aborting. Must be ≥ 1.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timer width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  16  request address
- req_wdata  in  8  write data; don't-care for reads
- req_is_write  in  1  1 = write, 0 = read
- resp_valid  out  1  response available; held until accepted
- resp_ready  in  1  response consumer ready
- resp_rdata  out  8  read data from frame byte0
- resp_is_write  out  1  echo of the latched req_is_write
- resp_err  out  1  flag-byte mismatch or timeout
- resp_timeout  out  1  response aborted by timeout
- tx_data  out  8  frame byte to UART adapter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART adapter can take a byte
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure
- busy  out  1  high in every state except IDLE
- stray_cnt  out  8  saturating count of discarded rx bytes

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready=1; latched request, rdata and flag registers 0; timer 0. Asynchronous reset aborts any frame in progress immediately; no partial byte is re-sent after reset.
- States: IDLE, SEND, WAIT_RESP0, WAIT_RESP1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr/wdata/is_write, set byte index to 0, go to SEND next cycle.
- SEND:
  - tx_valid=1. tx_data by index: 0=addr[7:0], 1=addr[15:8], 2=wdata (reads send latched wdata unchanged), 3={7'b0,is_write}.
  - tx_data is stable while tx_valid&&!tx_ready.
  - Each tx_valid&&tx_ready increments the index. The handshake on index 3 goes to WAIT_RESP0 with timer cleared.
  - Minimum 4 cycles in SEND with tx_ready tied high.
- WAIT_RESP0:
  - Timer increments every cycle.
  - rx_valid: latch rdata=rx_data, clear timer, go to WAIT_RESP1.
- WAIT_RESP1:
  - Timer increments every cycle.
  - rx_valid: latch flags, go to RESP.
  - resp_err = (rx_data[0] != latched is_write) || (rx_data[7:1] != 0); resp_timeout=0.
- Timeout:
  - In WAIT_RESP0/1, when timer == TIMEOUT_CYCLES-1 and no rx_valid that cycle, go to RESP with resp_err=1, resp_timeout=1, resp_rdata=0.
  - rx_valid in the same cycle as expiry wins; the byte is taken and no timeout occurs.
- RESP:
  - resp_valid=1; resp fields stable.
  - On resp_valid&&resp_ready, return to IDLE next cycle.
  - req_ready stays 0 until back in IDLE; no request bypass.
- Stray bytes: rx_valid in IDLE, SEND or RESP discards the byte and increments stray_cnt, saturating at 255. This covers late bytes after a timeout.
- resp_is_write always reflects the latched request, never the received flag byte.
- Timer saturates and never wraps.
- Latency with tx_ready=1 and a zero-delay rx source: request accept → first tx byte 1 cycle; last rx byte → resp_valid 1 cycle.

Test Plan:
- Write: addr 0x1234, wdata 0xA5, is_write=1, tx_ready=1 → tx bytes 0x34,0x12,0xA5,0x01. Inject rx 0x00,0x01 → resp_valid, rdata 0x00, resp_err 0, resp_timeout 0.
- Read with tx backpressure: addr 0x00FF, read, tx_ready toggling 1/0 → bytes 0xFF,0x00,wdata,0x00, each held stable while stalled. Rx 0x5C,0x00 → rdata 0x5C, err 0.
- Timeout: TIMEOUT_CYCLES=16, read, only rx 0x77 then silence → resp_timeout=1, resp_err=1, rdata 0x00. This must occur exactly 16 cycles after the 0x77 strobe. A later rx byte increments stray_cnt to 1.
- Flag mismatch: write request, response 0x00,0x00 → resp_err=1, resp_timeout=0. Response 0x00,0x81 → resp_err=1.
- Stray bytes and saturation: 300 rx strobes in IDLE → stray_cnt=255 and state stays IDLE. The next request completes normally.
- Reset mid-SEND after byte 1: assert rst_n=0 → tx_valid=0, busy=0, req_ready=1 immediately. A new request starts again at byte 0; resp_valid is held until resp_ready rises 5 cycles late.

Source files
------------

// File: rtl/bus_bridge_target_frame_codec.sv
// Target-side frame codec for the UART bus bridge.
// Serialises one bus request into a 4-byte request frame (addr lo, addr hi,
// wdata, direction flag), then collects the 2-byte response frame (rdata,
// flag) and presents a completed response with error/timeout indication.
module bus_bridge_target_frame_codec #(
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   input  logic        req_is_write,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [7:0]  resp_rdata,
   output logic        resp_is_write,
   output logic        resp_err,
   output logic        resp_timeout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic [7:0]  stray_cnt
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SEND       = 3'd1,
      S_WAIT_RESP0 = 3'd2,
      S_WAIT_RESP1 = 3'd3,
      S_RESP       = 3'd4
   } state_t;

   // Last timer value before a response byte is declared missing.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX  = '1;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      idx;
   logic [15:0]     addr_q;
   logic [7:0]      wdata_q;
   logic            is_write_q;
   logic [7:0]      rdata_q;
   logic            err_q;
   logic            timeout_q;
   logic [TO_W-1:0] timer;
   logic [7:0]      stray_q;
   logic            timer_exp;
   logic            in_wait;

   assign timer_exp = (timer == TO_LAST);
   assign in_wait   = (state == S_WAIT_RESP0) || (state == S_WAIT_RESP1);

   assign resp_rdata    = rdata_q;
   assign resp_is_write = is_write_q;
   assign resp_err      = err_q;
   assign resp_timeout  = timeout_q;
   assign stray_cnt     = stray_q;

   // State register; asynchronous reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs; rx byte arriving on the expiry cycle beats the timeout.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      tx_valid   = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = S_SEND;
         end
         S_SEND: begin
            tx_valid = 1'b1;
            if (tx_ready && (idx == 2'd3)) state_nxt = S_WAIT_RESP0;
         end
         S_WAIT_RESP0: begin
            if (rx_valid)       state_nxt = S_WAIT_RESP1;
            else if (timer_exp) state_nxt = S_RESP;
         end
         S_WAIT_RESP1: begin
            if (rx_valid || timer_exp) state_nxt = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame byte selection; held stable by the index only moving on a handshake.
   always_comb begin
      tx_data = 8'h00;
      if (state == S_SEND) begin
         case (idx)
            2'd0:    tx_data = addr_q[7:0];
            2'd1:    tx_data = addr_q[15:8];
            2'd2:    tx_data = wdata_q;
            default: tx_data = {7'b0, is_write_q};
         endcase
      end
   end

   // Request latch, byte index, response capture and inter-byte timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 2'd0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         is_write_q <= 1'b0;
         rdata_q    <= 8'h00;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
         timer      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  is_write_q <= req_is_write;
                  idx        <= 2'd0;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) timer <= '0;
               end
            end
            S_WAIT_RESP0: begin
               if (rx_valid) begin
                  rdata_q <= rx_data;
                  timer   <= '0;
               end else if (timer_exp) begin
                  rdata_q   <= 8'h00;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
               end else if (timer != TO_MAX) begin
                  timer <= timer + TO_W'(1);
               end
            end
            S_WAIT_RESP1: begin
               if (rx_valid) begin
                  err_q     <= (rx_data[0] != is_write_q) || (rx_data[7:1] != 7'd0);
                  timeout_q <= 1'b0;
               end else if (timer_exp) begin
                  rdata_q   <= 8'h00;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
               end else if (timer != TO_MAX) begin
                  timer <= timer + TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bytes arriving outside the response window are dropped and counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stray_q <= 8'h00;
      end else if (rx_valid && !in_wait && (stray_q != 8'hFF)) begin
         stray_q <= stray_q + 8'd1;
      end
   end

endmodule
